// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: default widths, FSM
// state encoding and the starvation counter width.
package dmem_arb_defs;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 32;
  localparam int WAIT_W     = 8;

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_FORCE  = 1'b1
  } arb_state_t;

  // Counter value seen on the last denied cycle before a forced grant.
  function automatic logic [WAIT_W-1:0] wait_thresh(input int max_wait);
    return WAIT_W'(max_wait - 1);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of processor, video and dmem-side signals around the arbiter.
//
// Handshakes:
//   cpu side  : cpu_en marks an access; if cpu_stall is high in that cycle
//               the access was not performed and the CPU re-presents the
//               identical access next cycle. Otherwise it completes in the
//               same cycle (cpu_q valid immediately for loads).
//   video side: vid_req is a request, vid_gnt the same-cycle grant. While
//               vid_req is high and not granted, vid_addr is held stable.
//               vid_valid pulses the cycle after each grant with vid_q.
//   mem side  : plain synchronous-RAM port, mem_q answers the address
//               presented in the same cycle.
interface dmem_arbiter_if #(
  parameter int ADDR_W = dmem_arb_defs::ADDR_W_DEF,
  parameter int DATA_W = dmem_arb_defs::DATA_W_DEF
);

  logic              cpu_en;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_data;
  logic              cpu_wren;
  logic [DATA_W-1:0] cpu_q;
  logic              cpu_stall;

  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_gnt;
  logic [DATA_W-1:0] vid_q;
  logic              vid_valid;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_q;

  // Arbiter side.
  modport slave (
    input  cpu_en, cpu_addr, cpu_data, cpu_wren, vid_req, vid_addr, mem_q,
    output cpu_q, cpu_stall, vid_gnt, vid_q, vid_valid,
           mem_addr, mem_data, mem_wren
  );

  // Environment side (processor, video requester and dmem together).
  modport master (
    output cpu_en, cpu_addr, cpu_data, cpu_wren, vid_req, vid_addr, mem_q,
    input  cpu_q, cpu_stall, vid_gnt, vid_q, vid_valid,
           mem_addr, mem_data, mem_wren
  );

endinterface

// File: rtl/arb_wait_counter.sv
// Saturating count of consecutive denied video cycles, with a compare
// output used to trigger the forced grant.
module arb_wait_counter
  import dmem_arb_defs::*;
#(
  parameter logic [WAIT_W-1:0] THRESH = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              inc,
  input  logic              clr,
  output logic [WAIT_W-1:0] count,
  output logic              at_thresh
);

  // Clear wins over increment; hold at all-ones instead of wrapping.
  always_ff @(posedge clock) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  assign at_thresh = (count == THRESH);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the dmem port between the processor (priority) and the video
// scanout reader. After MAX_WAIT consecutive denials the video requester
// is granted for one cycle and the processor is stalled if it wanted the
// port.
module dmem_arbiter
  import dmem_arb_defs::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_WAIT = 8
) (
  input  logic              clock,
  input  logic              reset,
  dmem_arbiter_if.slave     bus,
  output arb_state_t        dbg_state,
  output logic [WAIT_W-1:0] dbg_wait_cnt
);

  localparam logic [WAIT_W-1:0] THRESH = wait_thresh(MAX_WAIT);

  arb_state_t        state;
  arb_state_t        state_nxt;
  logic              vid_gnt;
  logic              cpu_stall;
  logic              wait_inc;
  logic              wait_clr;
  logic              at_thresh;
  logic [WAIT_W-1:0] wait_cnt;
  logic [ADDR_W-1:0] mux_addr;
  logic              mux_wren;
  logic [DATA_W-1:0] vid_q_r;
  logic              vid_valid_r;

  arb_wait_counter #(
    .THRESH(THRESH)
  ) u_wait (
    .clock    (clock),
    .reset    (reset),
    .inc      (wait_inc),
    .clr      (wait_clr),
    .count    (wait_cnt),
    .at_thresh(at_thresh)
  );

  // Denials accumulate only while video keeps asking.
  assign wait_inc = bus.vid_req && !vid_gnt;
  assign wait_clr = vid_gnt || !bus.vid_req;

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_NORMAL;
    end else begin
      state <= state_nxt;
    end
  end

  // Grant/stall decision and next state; FORCE lasts exactly one cycle.
  always_comb begin
    state_nxt = ST_NORMAL;
    vid_gnt   = bus.vid_req && (!bus.cpu_en || (state == ST_FORCE)) && !reset;
    cpu_stall = vid_gnt && bus.cpu_en;
    if ((state == ST_NORMAL) && bus.vid_req && !vid_gnt && at_thresh) begin
      state_nxt = ST_FORCE;
    end
  end

  // Port mux: video reads never write; CPU stores are blocked while stalled.
  always_comb begin
    mux_addr = bus.cpu_addr;
    mux_wren = bus.cpu_en && bus.cpu_wren && !cpu_stall && !reset;
    if (vid_gnt) begin
      mux_addr = bus.vid_addr;
      mux_wren = 1'b0;
    end
  end

  // Capture video read data at the end of the grant cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      vid_q_r     <= '0;
      vid_valid_r <= 1'b0;
    end else begin
      vid_valid_r <= vid_gnt;
      if (vid_gnt) begin
        vid_q_r <= bus.mem_q;
      end
    end
  end

  assign bus.mem_addr  = mux_addr;
  assign bus.mem_data  = bus.cpu_data;
  assign bus.mem_wren  = mux_wren;
  assign bus.cpu_q     = bus.mem_q;
  assign bus.cpu_stall = cpu_stall;
  assign bus.vid_gnt   = vid_gnt;
  assign bus.vid_q     = vid_q_r;
  assign bus.vid_valid = vid_valid_r;

  assign dbg_state    = state;
  assign dbg_wait_cnt = wait_cnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model
// that counts consecutive denials and tracks memory contents.
module tb_dmem_arbiter;
  import dmem_arb_defs::*;

  localparam int MAX_WAIT = 8;
  localparam int AW = 12;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic clock;
  logic reset;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b ();

  arb_state_t        dbg_state;
  logic [WAIT_W-1:0] dbg_wait_cnt;

  dmem_arbiter #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (b.slave),
    .dbg_state   (dbg_state),
    .dbg_wait_cnt(dbg_wait_cnt)
  );

  // dmem stand-in: read answers the current address, write on falling edge.
  logic [DW-1:0] ram [0:4095];
  assign b.mem_q = ram[b.mem_addr];
  always @(negedge clock) begin
    if (b.mem_wren) ram[b.mem_addr] = b.mem_data;
  end

  // ---------------- counters / check helper ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model + scoreboard ----------------
  logic [DW-1:0] ref_mem [0:4095];
  logic [DW-1:0] exp_q[$];          // video data awaiting its valid cycle
  int            denied_run = 0;    // consecutive denied video cycles
  logic          model_known = 1'b0;
  logic          e_vvalid = 1'b0;
  logic [DW-1:0] e_vq = '0;
  logic          pend_cpu = 1'b0;   // last CPU access was stalled
  logic          pend_vid = 1'b0;   // last video request was denied

  // Compare process: late in each cycle, before the dmem write edge.
  always @(posedge clock) begin
    logic          e_forced, e_gnt, e_stall, e_wren;
    logic [AW-1:0] e_addr;
    #4;
    e_forced = (denied_run == MAX_WAIT);
    e_gnt    = b.vid_req && (!b.cpu_en || e_forced) && !reset;
    e_stall  = e_gnt && b.cpu_en;
    e_wren   = !reset && b.cpu_en && b.cpu_wren && !e_gnt;
    e_addr   = e_gnt ? b.vid_addr : b.cpu_addr;

    chk("vid_gnt",   32'(b.vid_gnt),   32'(e_gnt));
    chk("cpu_stall", 32'(b.cpu_stall), 32'(e_stall));
    chk("mem_wren",  32'(b.mem_wren),  32'(e_wren));
    chk("mem_addr",  32'(b.mem_addr),  32'(e_addr));
    if (!e_gnt) chk("mem_data", b.mem_data, b.cpu_data);
    chk("cpu_q", b.cpu_q, ref_mem[e_addr]);
    if (model_known) begin
      chk("vid_valid", 32'(b.vid_valid), 32'(e_vvalid));
      chk("vid_q",     b.vid_q,          e_vq);
    end

    if (reset) begin
      denied_run  = 0;
      e_vvalid    = 1'b0;
      e_vq        = '0;
      exp_q.delete();
      model_known = 1'b1;
    end else begin
      if (b.vid_req && !e_gnt) denied_run++;
      else denied_run = 0;
      if (e_gnt) exp_q.push_back(ref_mem[b.vid_addr]);
      e_vvalid = e_gnt;
      if (e_gnt) e_vq = exp_q.pop_front();
      if (e_wren) ref_mem[b.cpu_addr] = b.cpu_data;
    end
    pend_cpu = e_stall;
    pend_vid = b.vid_req && !e_gnt;
  end

  // ---------------- driver ----------------
  task automatic drive(input logic en, input logic wr, input logic [AW-1:0] ca,
                       input logic [DW-1:0] cd, input logic vr,
                       input logic [AW-1:0] va, input logic rs);
    @(posedge clock);
    #1;
    b.cpu_en   = en;
    b.cpu_wren = wr;
    b.cpu_addr = ca;
    b.cpu_data = cd;
    b.vid_req  = vr;
    b.vid_addr = va;
    reset      = rs;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    logic          en, wr, vr, rs;
    logic [AW-1:0] ca, va;
    logic [DW-1:0] cd;
    int            p_cpu;

    for (int i = 0; i < 4096; i++) begin
      ram[i]     = 32'h1000_0000 + i;
      ref_mem[i] = 32'h1000_0000 + i;
    end
    ram[12'h200]     = 32'h0000_00A5;
    ref_mem[12'h200] = 32'h0000_00A5;

    reset = 1'b1;
    b.cpu_en = 1'b0; b.cpu_wren = 1'b0; b.cpu_addr = '0; b.cpu_data = '0;
    b.vid_req = 1'b0; b.vid_addr = '0;

    drive(1'b0, 1'b0, '0, '0, 1'b1, '0, 1'b1);
    chk("rst_gnt",  32'(b.vid_gnt),  32'd0);
    chk("rst_wren", 32'(b.mem_wren), 32'd0);
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1);
    idle();
    chk("rst_vvalid", 32'(b.vid_valid), 32'd0);
    chk("rst_vq",     b.vid_q,          32'd0);
    chk("rst_state",  32'(dbg_state),   32'(ST_NORMAL));
    chk("rst_wcnt",   32'(dbg_wait_cnt), 32'd0);

    // CPU only: store then load the same word.
    drive(1'b1, 1'b1, 12'h010, 32'hDEAD_BEEF, 1'b0, '0, 1'b0);
    chk("st_wren",  32'(b.mem_wren),  32'd1);
    chk("st_addr",  32'(b.mem_addr),  32'h010);
    chk("st_stall", 32'(b.cpu_stall), 32'd0);
    drive(1'b1, 1'b0, 12'h010, 32'h0, 1'b0, '0, 1'b0);
    chk("ld_q", b.cpu_q, 32'hDEAD_BEEF);

    // Video only.
    drive(1'b0, 1'b0, '0, '0, 1'b1, 12'h200, 1'b0);
    chk("vo_gnt",  32'(b.vid_gnt),  32'd1);
    chk("vo_wren", 32'(b.mem_wren), 32'd0);
    idle();
    chk("vo_valid", 32'(b.vid_valid), 32'd1);
    chk("vo_q",     b.vid_q,          32'h0000_00A5);
    idle();
    chk("vo_valid_off", 32'(b.vid_valid), 32'd0);

    // Starvation: continuous contention, forced grant every 9th cycle.
    for (int k = 1; k <= 19; k++) begin
      drive(1'b1, 1'b1, 12'h030, 32'hCAFE_0000, 1'b1, 12'h200, 1'b0);
      chk("sv_gnt",   32'(b.vid_gnt),   32'(k == 9 || k == 18));
      chk("sv_stall", 32'(b.cpu_stall), 32'(k == 9 || k == 18));
      chk("sv_wren",  32'(b.mem_wren),  32'(!(k == 9 || k == 18)));
      if (k == 9)  chk("sv_state", 32'(dbg_state), 32'(ST_FORCE));
      if (k == 10) chk("sv_wcnt",  32'(dbg_wait_cnt), 32'd0);
    end
    idle();

    // Withdrawal in the forced cycle with a CPU store.
    for (int k = 1; k <= 8; k++) drive(1'b1, 1'b0, 12'h005, '0, 1'b1, 12'h201, 1'b0);
    drive(1'b1, 1'b1, 12'h020, 32'h1234_5678, 1'b0, 12'h201, 1'b0);
    chk("wd_state", 32'(dbg_state),   32'(ST_FORCE));
    chk("wd_gnt",   32'(b.vid_gnt),   32'd0);
    chk("wd_stall", 32'(b.cpu_stall), 32'd0);
    chk("wd_wren",  32'(b.mem_wren),  32'd1);
    drive(1'b1, 1'b0, 12'h020, '0, 1'b0, '0, 1'b0);
    chk("wd_q",      b.cpu_q,          32'h1234_5678);
    chk("wd_state2", 32'(dbg_state),   32'(ST_NORMAL));
    chk("wd_wcnt",   32'(dbg_wait_cnt), 32'd0);

    // Reset mid-wait.
    for (int k = 1; k <= 5; k++) drive(1'b1, 1'b0, 12'h006, '0, 1'b1, 12'h200, 1'b0);
    chk("rw_wcnt5", 32'(dbg_wait_cnt), 32'd4);
    drive(1'b1, 1'b1, 12'h007, 32'h5555_AAAA, 1'b1, 12'h200, 1'b1);
    chk("rw_gnt",  32'(b.vid_gnt),  32'd0);
    chk("rw_wren", 32'(b.mem_wren), 32'd0);
    for (int k = 1; k <= 9; k++) begin
      drive(1'b1, 1'b0, 12'h006, '0, 1'b1, 12'h200, 1'b0);
      if (k == 1) begin
        chk("rw_vvalid", 32'(b.vid_valid), 32'd0);
        chk("rw_vq",     b.vid_q,          32'd0);
      end
      chk("rw_gnt2", 32'(b.vid_gnt), 32'(k == 9));
    end
    idle();

    // Simultaneous request: CPU first, video next cycle.
    drive(1'b1, 1'b0, 12'h008, '0, 1'b1, 12'h200, 1'b0);
    chk("sm_gnt0", 32'(b.vid_gnt), 32'd0);
    drive(1'b0, 1'b0, '0, '0, 1'b1, 12'h200, 1'b0);
    chk("sm_gnt1", 32'(b.vid_gnt), 32'd1);
    idle();
    chk("sm_wcnt", 32'(dbg_wait_cnt), 32'd0);
    chk("sm_vq",   b.vid_q,           32'h0000_00A5);

    // Randomized traffic obeying the re-present / hold-address rules.
    en = 1'b0; wr = 1'b0; ca = '0; cd = '0; vr = 1'b0; va = '0;
    for (int i = 0; i < 3000; i++) begin
      p_cpu = (i < 1000) ? 3 : ((i < 2000) ? 10 : 1);
      rs = ($urandom_range(0, 149) == 0);
      if (!pend_cpu) begin
        en = ($urandom_range(0, 10) < p_cpu);
        wr = $urandom_range(0, 1);
        ca = 12'($urandom_range(0, 31));
        cd = $urandom;
      end
      if (pend_vid) begin
        vr = ($urandom_range(0, 9) != 0);
      end else begin
        vr = $urandom_range(0, 1);
        va = 12'($urandom_range(0, 31));
      end
      drive(en, wr, ca, cd, vr, va, rs);
    end

    idle();
    idle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
